l1_request_gen: RTL and testbench
=================================

# l1_request_gen

Request-side front end for the L1 lookup/update engine. Buffers incoming 32-bit byte addresses in a small FIFO and splits each into tag, index and block offset. Runs the L1 `find_start` / `updated` handshake one access at a time and keeps access, hit and miss statistics. Sits between the address trace source and the L1 cache.

## Interface
- `BLOCK_SIZE_BYTE`, 16, line size; offset width `OFF_W = log2(BLOCK_SIZE_BYTE)` = 4
- `SET`, 512, number of L1 sets; index width `IDX_W = log2(SET)` = 9
- `TAG_W`, 32-IDX_W-OFF_W = 19, tag width
- `FIFO_DEPTH`, 4, address FIFO entries (power of 2)
- `TIMEOUT`, 255, maximum WAIT cycles before abort

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `addr_valid`  in  1  trace source has an address
- `addr_in`  in  32  byte address
- `addr_ready`  out  1  FIFO not full; push when `addr_valid & addr_ready`
- `tag`  out  TAG_W  `addr[31:13]` of the current access
- `index`  out  IDX_W  `addr[12:4]`
- `block_offset`  out  OFF_W  `addr[3:0]`
- `find_start`  out  1  one-cycle lookup request to L1
- `found_in_cache`  in  1  L1 hit flag; valid while `updated`=1
- `updated`  in  1  L1 completion pulse
- `access_count`, `hit_count`, `miss_count`  out  20 each  saturating statistics
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty
- `timeout_err`  out  1  sticky; set on a WAIT timeout

## Operation
- Reset (`reset`=0 at an edge): FIFO empty, FSM in IDLE. All counters 0. `find_start`, `timeout_err`, `busy` = 0. `tag`/`index`/`block_offset` = 0. `addr_ready` = 1 in the first cycle after reset. Reset mid-access abandons the access without counting it.
- FIFO: circular buffer with wrapping read/write pointers and an occupancy count 0..FIFO_DEPTH.
  - Push and pop in the same cycle leave occupancy unchanged.
  - When full, `addr_ready` = 0 and the input is ignored.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, register tag/index/offset, go to ISSUE.
  - ISSUE: `find_start` = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: hold tag/index/offset stable and increment the timeout counter. When `updated`=1, act on `found_in_cache` and go to GAP; the completion rules are listed below. If the counter reaches TIMEOUT with no `updated`, set `timeout_err` and go to IDLE; the aborted access is not counted.
  - GAP: one idle cycle so the L1 returns to its idle state. Then go to IDLE.
- Completion in WAIT (cycle with `updated`=1):
  - `access_count` increments.
  - If `found_in_cache`=1, `hit_count` increments; otherwise `miss_count` increments.
- Counters saturate at 0xFFFFF.
- `updated` or `find_start` activity outside WAIT is ignored.
- `timeout_err` clears only on reset.

## Timing
- Push accepted at edge N into an empty FIFO with the FSM in IDLE:
  - pop at edge N+1;
  - `find_start` high during cycle N+2 (registered output, ISSUE);
  - WAIT from N+3.
- Field outputs change only on the pop edge, so they are stable for the whole ISSUE..GAP window.
- Minimum access period with an immediate `updated` is 4 cycles: ISSUE, WAIT (≥1 cycle), GAP, IDLE.
- Counters update on the edge that ends the WAIT cycle in which `updated`=1.
- `addr_ready` is combinational from occupancy. It is low in the same cycle the FIFO becomes full.

## Test plan
- Field split: push 0x0001_2345 → `tag`=0x00009, `index`=0x034, `block_offset`=0x5; `find_start` pulses for exactly 1 cycle, 2 cycles after the push.
- Hit and miss accounting: 3 accesses; the responder returns `updated` after 3 cycles with `found_in_cache`=1,0,1 → access=3, hit=2, miss=1; `find_start` pulses are ≥4 cycles apart.
- FIFO full and back-pressure: hold `addr_valid`=1 with 6 distinct addresses while the responder stalls → `addr_ready` drops after 4 FIFO entries plus 1 in flight. All 6 addresses are issued in order, with none lost or duplicated across pointer wrap.
- Timeout: the responder never asserts `updated` → `timeout_err`=1 after 255 WAIT cycles, counters unchanged, the next queued address is issued afterwards, and `timeout_err` stays 1.
- Reset mid-WAIT: `reset`=0 for 1 cycle during WAIT → all counters and outputs at reset values, FIFO empty, `addr_ready`=1; a later `updated` pulse is ignored.
- Saturation: preload via 2^20 hits (or force counters to 0xFFFFE) and run 2 hits → `hit_count` and `access_count` hold at 0xFFFFF.

Source files
------------

// File: rtl/l1_request_gen.sv
// Request front end for the L1 lookup engine: buffers byte addresses, splits them
// into tag/index/offset and runs the find_start/updated handshake one access at a time.
module l1_request_gen #(
   parameter int BLOCK_SIZE_BYTE = 16,
   parameter int SET             = 512,
   parameter int FIFO_DEPTH      = 4,
   parameter int TIMEOUT         = 255,
   parameter int OFF_W           = $clog2(BLOCK_SIZE_BYTE),
   parameter int IDX_W           = $clog2(SET),
   parameter int TAG_W           = 32 - IDX_W - OFF_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             addr_valid,
   input  logic [31:0]      addr_in,
   output logic             addr_ready,
   output logic [TAG_W-1:0] tag,
   output logic [IDX_W-1:0] index,
   output logic [OFF_W-1:0] block_offset,
   output logic             find_start,
   input  logic             found_in_cache,
   input  logic             updated,
   output logic [19:0]      access_count,
   output logic [19:0]      hit_count,
   output logic [19:0]      miss_count,
   output logic             busy,
   output logic             timeout_err
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

   state_t           r_state, w_next;
   logic [31:0]      r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [OCC_W-1:0] r_occ;
   logic [TO_W-1:0]  r_to_cnt;
   logic [31:0]      r_addr;
   logic             r_find_start, r_timeout_err;
   logic [19:0]      r_acc_cnt, r_hit_cnt, r_miss_cnt;
   logic             w_push, w_pop, w_done, w_abort;

   function automatic logic [19:0] sat_inc(input logic [19:0] v);
      return (v == 20'hFFFFF) ? v : v + 20'd1;
   endfunction

   assign addr_ready = (r_occ != OCC_W'(FIFO_DEPTH));
   assign w_push     = addr_valid & addr_ready;
   assign w_pop      = (r_state == S_IDLE) && (r_occ != '0);
   assign w_done     = (r_state == S_WAIT) && updated;
   // updated wins over the timeout when both land in the last WAIT cycle
   assign w_abort    = (r_state == S_WAIT) && !updated && (r_to_cnt == TO_W'(TIMEOUT - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_pop) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (w_done) w_next = S_GAP;
                  else if (w_abort) w_next = S_IDLE;
         S_GAP:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= addr_in;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_occ         <= '0;
         r_to_cnt      <= '0;
         r_addr        <= '0;
         r_find_start  <= 1'b0;
         r_timeout_err <= 1'b0;
         r_acc_cnt     <= '0;
         r_hit_cnt     <= '0;
         r_miss_cnt    <= '0;
      end else begin
         r_state      <= w_next;
         r_find_start <= w_pop;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
         if (w_pop) r_addr <= r_mem[r_rd_ptr];
         if (r_state == S_ISSUE)     r_to_cnt <= '0;
         else if (r_state == S_WAIT) r_to_cnt <= r_to_cnt + TO_W'(1);
         if (w_abort) r_timeout_err <= 1'b1;
         if (w_done) begin
            r_acc_cnt <= sat_inc(r_acc_cnt);
            if (found_in_cache) r_hit_cnt  <= sat_inc(r_hit_cnt);
            else                r_miss_cnt <= sat_inc(r_miss_cnt);
         end
      end
   end

   assign tag          = r_addr[31:OFF_W+IDX_W];
   assign index        = r_addr[OFF_W+IDX_W-1:OFF_W];
   assign block_offset = r_addr[OFF_W-1:0];
   assign find_start   = r_find_start;
   assign timeout_err  = r_timeout_err;
   assign access_count = r_acc_cnt;
   assign hit_count    = r_hit_cnt;
   assign miss_count   = r_miss_cnt;
   assign busy         = (r_state != S_IDLE) || (r_occ != '0);

endmodule

// File: tb/tb_l1_request_gen.sv
// Directed bench for l1_request_gen: field split, hit/miss stats, back-pressure,
// timeout, reset during WAIT and counter saturation.
module tb_l1_request_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        addr_valid = 1'b0;
   logic [31:0] addr_in = '0;
   logic        addr_ready;
   logic [18:0] tag;
   logic [8:0]  index;
   logic [3:0]  block_offset;
   logic        find_start;
   logic        rsp_updated = 1'b0, rsp_found = 1'b0;
   logic        man_updated = 1'b0, man_found = 1'b0;
   logic [19:0] access_count, hit_count, miss_count;
   logic        busy, timeout_err;

   int checks = 0, passed = 0, fails = 0;
   int cyc = 0;
   logic [31:0] mon_q[$];
   int          mon_cyc[$];

   int   resp_en = 0;
   int   resp_dly = 1;
   logic resp_hits[$];

   l1_request_gen dut (
      .clk(clk), .reset(reset), .addr_valid(addr_valid), .addr_in(addr_in),
      .addr_ready(addr_ready), .tag(tag), .index(index), .block_offset(block_offset),
      .find_start(find_start), .found_in_cache(rsp_found | man_found),
      .updated(rsp_updated | man_updated), .access_count(access_count),
      .hit_count(hit_count), .miss_count(miss_count), .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // issue monitor: records the address presented with every find_start pulse
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (find_start === 1'b1) begin
         mon_q.push_back({tag, index, block_offset});
         mon_cyc.push_back(cyc);
      end
   end

   // L1 responder model: pulses updated resp_dly cycles after find_start
   initial begin
      logic h;
      forever begin
         @(posedge clk); #1;
         if (find_start === 1'b1 && resp_en != 0) begin
            h = (resp_hits.size() > 0) ? resp_hits.pop_front() : 1'b1;
            repeat (resp_dly) begin @(posedge clk); #1; end
            rsp_updated = 1'b1; rsp_found = h;
            @(posedge clk); #1;
            rsp_updated = 1'b0; rsp_found = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", t, obs, exp);
      end
   endtask

   task automatic wait_idle(input int budget, input string t);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin tick(); n++; end
      chk(t, 32'(busy), 32'd0);
   endtask

   task automatic chk_rst(input string p);
      chk({p, "_acc"}, 32'(access_count), 32'd0);
      chk({p, "_hit"}, 32'(hit_count), 32'd0);
      chk({p, "_miss"}, 32'(miss_count), 32'd0);
      chk({p, "_fs"}, 32'(find_start), 32'd0);
      chk({p, "_terr"}, 32'(timeout_err), 32'd0);
      chk({p, "_busy"}, 32'(busy), 32'd0);
      chk({p, "_fields"}, {tag, index, block_offset}, 32'd0);
      chk({p, "_ready"}, 32'(addr_ready), 32'd1);
   endtask

   task automatic push_one(input logic [31:0] a);
      addr_valid = 1'b1; addr_in = a;
      tick();
      addr_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] hm[3];
      logic [31:0] fa[6];
      int base, k, k_full, n;
      logic acc;

      hm[0] = 32'h0000_1000; hm[1] = 32'h0004_2128; hm[2] = 32'hFFFF_FFFF;
      for (int i = 0; i < 6; i++) fa[i] = 32'hA000_0000 + i * 32'h0002_0010 + i;

      // ---- reset state
      reset = 1'b0; tick(); tick(); reset = 1'b1;
      chk_rst("rst");

      // ---- field split and find_start timing
      resp_en = 1; resp_dly = 1;
      push_one(32'h0001_2345);
      chk("fs_push_cycle", 32'(find_start), 32'd0);
      chk("busy_after_push", 32'(busy), 32'd1);
      tick();
      chk("fs_pulse", 32'(find_start), 32'd1);
      chk("tag", 32'(tag), 32'h0000_0009);
      chk("index", 32'(index), 32'h0000_0034);
      chk("offset", 32'(block_offset), 32'h0000_0005);
      tick();
      chk("fs_one_cycle", 32'(find_start), 32'd0);
      chk("fields_stable", {tag, index, block_offset}, 32'h0001_2345);
      tick();
      chk("split_acc", 32'(access_count), 32'd1);
      chk("split_hit", 32'(hit_count), 32'd1);
      chk("split_busy_gap", 32'(busy), 32'd1);
      tick();
      chk("split_idle", 32'(busy), 32'd0);

      // ---- hit / miss accounting from a clean reset
      reset = 1'b0; tick(); reset = 1'b1;
      resp_dly = 3;
      resp_hits.push_back(1'b1); resp_hits.push_back(1'b0); resp_hits.push_back(1'b1);
      base = mon_q.size();
      addr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin addr_in = hm[i]; tick(); end
      addr_valid = 1'b0;
      wait_idle(100, "hm_idle");
      chk("hm_acc", 32'(access_count), 32'd3);
      chk("hm_hit", 32'(hit_count), 32'd2);
      chk("hm_miss", 32'(miss_count), 32'd1);
      chk("hm_issued", 32'(mon_q.size() - base), 32'd3);
      if (mon_q.size() - base == 3) begin
         for (int i = 0; i < 3; i++) chk("hm_order", mon_q[base + i], hm[i]);
         chk("hm_gap1", 32'(mon_cyc[base + 1] - mon_cyc[base] >= 4), 32'd1);
         chk("hm_gap2", 32'(mon_cyc[base + 2] - mon_cyc[base + 1] >= 4), 32'd1);
      end

      // ---- FIFO full / back-pressure with a slow responder
      resp_dly = 20;
      base = mon_q.size();
      k = 0; k_full = -1;
      addr_valid = 1'b1; addr_in = fa[0];
      for (int c = 0; c < 200 && k < 6; c++) begin
         acc = addr_ready;
         tick();
         if (acc) begin
            k++;
            if (k < 6) addr_in = fa[k];
         end
         if (addr_ready === 1'b0 && k_full < 0) k_full = k;
      end
      addr_valid = 1'b0;
      chk("full_all_pushed", 32'(k), 32'd6);
      chk("full_ready_drop_at", 32'(k_full), 32'd5);
      wait_idle(600, "full_idle");
      chk("full_issued", 32'(mon_q.size() - base), 32'd6);
      if (mon_q.size() - base == 6)
         for (int i = 0; i < 6; i++) chk("full_order", mon_q[base + i], fa[i]);
      chk("full_acc", 32'(access_count), 32'd9);
      chk("full_hit", 32'(hit_count), 32'd8);
      chk("full_miss", 32'(miss_count), 32'd1);

      // ---- timeout: responder silent
      resp_en = 0;
      addr_valid = 1'b1; addr_in = 32'h1234_5678; tick();
      addr_in = 32'h8765_4320; tick();
      addr_valid = 1'b0;
      chk("to_issue", 32'(find_start), 32'd1);
      chk("to_fields", {tag, index, block_offset}, 32'h1234_5678);
      n = 0;
      repeat (255) begin tick(); n++; end
      chk("to_not_yet", 32'(timeout_err), 32'd0);
      tick();
      chk("to_set", 32'(timeout_err), 32'd1);
      chk("to_acc", 32'(access_count), 32'd9);
      chk("to_hit", 32'(hit_count), 32'd8);
      chk("to_miss", 32'(miss_count), 32'd1);
      tick();
      chk("to_next_issue", 32'(find_start), 32'd1);
      chk("to_next_fields", {tag, index, block_offset}, 32'h8765_4320);
      chk("to_sticky", 32'(timeout_err), 32'd1);

      // ---- reset in the middle of WAIT
      tick(); tick();
      chk("mid_busy", 32'(busy), 32'd1);
      reset = 1'b0; tick(); reset = 1'b1;
      chk_rst("midrst");
      man_updated = 1'b1; man_found = 1'b1; tick();
      man_updated = 1'b0; man_found = 1'b0; tick();
      chk("late_upd_acc", 32'(access_count), 32'd0);
      chk("late_upd_hit", 32'(hit_count), 32'd0);
      chk("late_upd_busy", 32'(busy), 32'd0);

      // ---- saturation from a preloaded count
      dut.r_acc_cnt = 20'hFFFFE;
      dut.r_hit_cnt = 20'hFFFFE;
      resp_en = 1; resp_dly = 1;
      addr_valid = 1'b1; addr_in = 32'h0000_0010; tick();
      addr_in = 32'h0000_0020; tick();
      addr_valid = 1'b0;
      wait_idle(50, "sat_idle");
      chk("sat_acc", 32'(access_count), 32'h000F_FFFF);
      chk("sat_hit", 32'(hit_count), 32'h000F_FFFF);
      chk("sat_miss", 32'(miss_count), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
